// File: rtl/cdc_handshake_req_initiator.sv
// cdc_handshake_req_initiator
// Source-domain initiator of a toggle REQ/ACK clock-domain-crossing handshake.
// It captures one word on a valid/ready interface and holds it on xfer_data.
// It flips req_toggle, then waits until the synchronized ack toggle matches
// req_toggle again. A completion gives a one-cycle done pulse.
//
// Optional build macro: CDC_HS_TIMEOUT_EN
//   When defined, a WAIT_ACK down-counter declares timeout_err after
//   TIMEOUT_CYCLES cycles and moves the FSM to ERROR.
//   When undefined, WAIT_ACK waits indefinitely and timeout_err is always 0.
//
// state    | meaning
// IDLE     | ready for a new word; an ack/req mismatch here is a protocol error
// WAIT_ACK | request toggled, waiting for the ack toggle to match it
// ERROR    | ack timed out (timeout build only); leaves on err_clr
module cdc_handshake_req_initiator #(
  parameter int DATA_W         = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk_src,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] xfer_data,
  output logic              req_toggle,
  input  logic              ack_toggle_async,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  xfer_count,
  output logic              proto_err,
  output logic              timeout_err,
  input  logic              err_clr
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be in 2..4");
  end
  if (TIMEOUT_CYCLES < 4) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic                   ack_match;

  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              proto_q, proto_d;
  logic              tmo_q, tmo_d;

  logic accept;
  logic complete;
  logic timeout_hit;
  logic err_exit;

  // Only the last synchronizer stage is used; earlier stages may be metastable.
  assign ack_s     = ack_sync_q[SYNC_STAGES-1];
  assign ack_match = (ack_s == req_q);

  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign complete = (state_q == ST_WAIT_ACK) && ack_match;

`ifdef CDC_HS_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

  logic [TMR_W-1:0] tmr_q, tmr_d;

  assign timeout_hit = (state_q == ST_WAIT_ACK) && !ack_match && (tmr_q == '0);
  assign err_exit    = (state_q == ST_ERROR) && err_clr;

  // The timer is loaded when a word is accepted and counts down only in WAIT_ACK.
  always_comb begin
    tmr_d = tmr_q;
    if (accept) begin
      tmr_d = TMR_W'(TIMEOUT_CYCLES - 1);
    end else if (state_q == ST_WAIT_ACK && tmr_q != '0) begin
      tmr_d = tmr_q - TMR_W'(1);
    end
  end

  // Timeout timer register.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_exit    = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_match)        state_d = ST_WAIT_ACK == ST_WAIT_ACK ? ST_IDLE : ST_IDLE;
        else if (timeout_hit) state_d = ST_ERROR;
      end
      ST_ERROR: begin
        if (err_exit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs that depend only on the current state.
  always_comb begin
    in_ready = (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
  end

  // Next values for the request toggle, data, counter and sticky error flags.
  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d = ~req_q;
    end else if (err_exit) begin
      // Realign with the destination so that the next transfer starts clean.
      req_d = ack_s;
    end

    data_d = accept ? in_data : data_q;
    done_d = complete;
    cnt_d  = complete ? cnt_q + CNT_W'(1) : cnt_q;

    // Setting an error takes priority over clearing it in the same cycle.
    proto_d = proto_q;
    if (state_q == ST_IDLE && !ack_match) begin
      proto_d = 1'b1;
    end else if (err_clr) begin
      proto_d = 1'b0;
    end

    tmo_d = tmo_q;
    if (timeout_hit) begin
      tmo_d = 1'b1;
    end else if (err_clr) begin
      tmo_d = 1'b0;
    end
  end

  // Ack synchronizer and datapath registers.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      ack_sync_q <= '0;
      req_q      <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      proto_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_toggle_async};
      req_q      <= req_d;
      data_q     <= data_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      proto_q    <= proto_d;
      tmo_q      <= tmo_d;
    end
  end

  assign xfer_data   = data_q;
  assign req_toggle  = req_q;
  assign done        = done_q;
  assign xfer_count  = cnt_q;
  assign proto_err   = proto_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_cdc_handshake_req_initiator.sv
// Testbench for cdc_handshake_req_initiator: a behavioural model is checked
// every cycle, and directed scenarios add fixed expected values.
module tb_cdc_handshake_req_initiator;

  localparam int DW  = 32;
  localparam int SS  = 2;
  localparam int TMO = 8;
  localparam int CW  = 8;
`ifdef CDC_HS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk_src = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] xfer_data;
  logic          req_toggle;
  logic          ack_async = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] xfer_count;
  logic          proto_err;
  logic          timeout_err;
  logic          err_clr = 1'b0;

  cdc_handshake_req_initiator #(
    .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk_src(clk_src), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .xfer_data(xfer_data), .req_toggle(req_toggle),
    .ack_toggle_async(ack_async), .busy(busy), .done(done),
    .xfer_count(xfer_count), .proto_err(proto_err), .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk_src = ~clk_src;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 = idle, 1 = waiting for ack, 2 = timed out.
  int          m_mode = 0;
  int          m_wait = 0;
  bit          m_req = 0;
  logic [DW-1:0] m_data = '0;
  bit          m_done = 0;
  int          m_count = 0;
  bit          m_proto = 0;
  bit          m_tmo = 0;
  bit          hist [SS];

  always @(posedge clk_src) begin
    bit a_s;
    if (rst) begin
      m_mode = 0; m_wait = 0; m_req = 0; m_data = '0; m_done = 0;
      m_count = 0; m_proto = 0; m_tmo = 0;
      for (int i = 0; i < SS; i++) hist[i] = 1'b0;
    end else begin
      a_s = hist[SS-1];
      m_done = 0;
      if (m_mode == 0 && a_s != m_req) m_proto = 1;
      else if (err_clr) m_proto = 0;
      if (!(m_mode == 1 && a_s != m_req && TMO_EN && m_wait + 1 == TMO) && err_clr) m_tmo = 0;
      case (m_mode)
        0: if (in_valid) begin
             m_data = in_data; m_req = !m_req; m_mode = 1; m_wait = 0;
           end
        1: begin
             m_wait++;
             if (a_s == m_req) begin
               m_done = 1; m_count = (m_count + 1) % (1 << CW); m_mode = 0;
             end else if (TMO_EN && m_wait == TMO) begin
               m_tmo = 1; m_mode = 2;
             end
           end
        default: if (err_clr) begin m_mode = 0; m_req = a_s; end
      endcase
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ack_async;
    end
  end

  // Compare the DUT against the model on every cycle.
  always @(negedge clk_src) begin
    if (chk_en && !rst) begin
      chk("in_ready", in_ready, m_mode == 0);
      chk("busy", busy, m_mode != 0);
      chk("req_toggle", req_toggle, m_req);
      chk("xfer_data", xfer_data, m_data);
      chk("done", done, m_done);
      chk("xfer_count", xfer_count, m_count);
      chk("proto_err", proto_err, m_proto);
      chk("timeout_err", timeout_err, m_tmo);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_src);
  endtask

  task automatic do_reset();
    rst = 1; ack_async = 0; in_valid = 0; err_clr = 0;
    tick(2);
    rst = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 40) begin tick(1); n++; end
    chk(nm, done, 1'b1);
  endtask

  task automatic do_xfer(input logic [DW-1:0] d, input int dly);
    in_valid = 1; in_data = d;
    tick(1);
    in_valid = 0;
    tick(dly);
    ack_async = m_req;
    wait_done("xfer_done_wait");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] req_seq;
    logic [3:0] req_exp;
    int dly;

    // Reset state and a single transfer with exact latency.
    do_reset();
    chk_en = 1;
    tick(1);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_req", req_toggle, 1'b0);
    chk("rst_count", xfer_count, 0);
    chk("rst_busy", busy, 1'b0);
    in_valid = 1; in_data = 32'hA5A5_0001;
    tick(1);
    in_valid = 0;
    chk("t1_req", req_toggle, 1'b1);
    chk("t1_data", xfer_data, 32'hA5A5_0001);
    chk("t1_busy", busy, 1'b1);
    ack_async = 1;
    tick(1);
    chk("t1_done_e0", done, 1'b0);
    tick(1);
    chk("t1_done_e1", done, 1'b0);
    tick(1);
    chk("t1_done_e2", done, 1'b1);
    chk("t1_count", xfer_count, 1);
    chk("t1_in_ready", in_ready, 1'b1);
    tick(1);
    chk("t1_done_drop", done, 1'b0);

    // Back-to-back words: the next word is offered in the done cycle.
    do_reset();
    tick(1);
    req_exp = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = DW'(i + 1);
      tick(1);
      in_valid = 0;
      req_seq[i] = req_toggle;
      chk("b2b_data", xfer_data, i + 1);
      tick(4);
      ack_async = m_req;
      wait_done("b2b_done_wait");
    end
    chk("b2b_req_seq", req_seq, req_exp);
    chk("b2b_count", xfer_count, 4);

    // Spurious ack while idle, clear, and set-wins-over-clear.
    tick(2);
    ack_async = ~ack_async;
    tick(SS + 1);
    chk("proto_set", proto_err, 1'b1);
    ack_async = ~ack_async;
    tick(4);
    chk("proto_sticky", proto_err, 1'b1);
    err_clr = 1; tick(1); err_clr = 0;
    chk("proto_clr", proto_err, 1'b0);
    ack_async = ~ack_async;
    tick(SS);
    err_clr = 1; tick(1); err_clr = 0;
    chk("proto_set_wins", proto_err, 1'b1);
    ack_async = ~ack_async;
    tick(4);
    err_clr = 1; tick(1); err_clr = 0;
    chk("proto_clr2", proto_err, 1'b0);

    // Reset in the middle of WAIT_ACK, then a normal transfer.
    in_valid = 1; in_data = 32'hDEAD_BEEF;
    tick(1);
    in_valid = 0;
    tick(2);
    rst = 1; ack_async = 0;
    tick(1);
    rst = 0;
    chk("mid_rst_req", req_toggle, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_count", xfer_count, 0);
    do_xfer(32'h1234_5678, 2);
    chk("mid_rst_after", xfer_count, 1);

    // Counter wrap.
    do_reset();
    tick(1);
    for (int i = 0; i < (1 << CW) - 1; i++) do_xfer(DW'($urandom), 1);
    chk("wrap_full", xfer_count, (1 << CW) - 1);
    do_xfer(32'h0000_CAFE, 1);
    chk("wrap_zero", xfer_count, 0);

`ifdef CDC_HS_TIMEOUT_EN
    // No ack: timeout after TMO WAIT_ACK cycles, then recovery.
    do_reset();
    tick(1);
    in_valid = 1; in_data = 32'h0BAD_0001;
    tick(1);
    in_valid = 0;
    tick(TMO - 1);
    chk("tmo_not_yet", timeout_err, 1'b0);
    tick(1);
    chk("tmo_set", timeout_err, 1'b1);
    chk("tmo_busy", busy, 1'b1);
    chk("tmo_in_ready", in_ready, 1'b0);
    tick(3);
    chk("tmo_no_done", done, 1'b0);
    err_clr = 1; tick(1); err_clr = 0;
    chk("tmo_req_aligned", req_toggle, 1'b0);
    chk("tmo_idle", in_ready, 1'b1);
    chk("tmo_clr", timeout_err, 1'b0);
    do_xfer(32'h600D_0002, 3);
    chk("tmo_next_count", xfer_count, 1);
`endif

    // Randomized traffic with a destination that acks after a random delay.
    do_reset();
    tick(1);
    dly = 0;
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom % 3) == 0;
      in_data  = $urandom;
      err_clr  = ($urandom % 12) == 0;
      if ($urandom % 250 == 0) begin
        ack_async = ~ack_async;
      end else if (ack_async != m_req) begin
        if (dly == 0) ack_async = m_req;
        else dly--;
      end else begin
        dly = $urandom_range(0, 10);
      end
      tick(1);
    end
    in_valid = 0; err_clr = 0;
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
